riscv_v_redand_collect: RTL and testbench

Sequential collector on the result side of the vector bitwise-AND unit for `vredand` reductions spanning multiple ALU data beats (LMUL > 1). It accepts one reduced byte-vector result per beat, extracts the reduced element, and AND-folds it into an accumulator seeded with the scalar operand vs1[0]. It then presents the final element for writeback to vd[0] over a valid/ready handshake. It sits between the AND unit output and the vector writeback stage.

---
 rtl/riscv_v_redand_collect.sv | 141 ++++++++++++++
 tb/tb_riscv_v_redand_collect.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_redand_collect.sv
// Result-side collector for multi-beat vredand: AND-folds the top element of each
// beat into a seed taken from vs1[0], then hands the final element to writeback.
module riscv_v_redand_collect #(
  parameter int NUM_BYTES  = 16,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      osize,
  input  logic [2:0]                      num_beats_m1,
  input  logic [63:0]                     scalar_init,
  input  logic                            chunk_valid,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0] chunk_result,
  output logic                            chunk_ready,
  output logic                            wb_valid,
  output logic [63:0]                     wb_data,
  input  logic                            wb_ready,
  output logic                            busy
);

  localparam int DW = NUM_BYTES * BYTE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WB      = 2'd2
  } state_t;

  function automatic logic [63:0] elem_mask(input logic [1:0] os);
    logic [63:0] m;
    case (os)
      2'd0:    m = 64'h0000_0000_0000_00FF;
      2'd1:    m = 64'h0000_0000_0000_FFFF;
      2'd2:    m = 64'h0000_0000_FFFF_FFFF;
      2'd3:    m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = 64'h0000_0000_0000_0000;
    endcase
    return m;
  endfunction

  // The reduced element lives in the most-significant bytes of the beat.
  function automatic logic [63:0] top_elem(input logic [DW-1:0] data, input logic [1:0] os);
    logic [DW-1:0] sh;
    int            shamt;
    shamt = DW - (BYTE_WIDTH << int'(os));
    sh    = data >> shamt;
    return sh[63:0] & elem_mask(os);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_osize;
  logic [2:0]  r_nbm1;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [63:0] r_acc;
  logic [63:0] w_acc_nxt;
  logic [63:0] w_elem;
  logic        r_chunk_ready;
  logic        r_wb_valid;
  logic        r_busy;
  logic [63:0] r_wb_data;

  assign w_elem = top_elem(chunk_result, r_osize);

  // Next-state, accumulator and beat-counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COLLECT;
          w_acc_nxt   = scalar_init & elem_mask(osize);
          w_cnt_nxt   = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (chunk_valid) begin
          w_acc_nxt = r_acc & w_elem;
          if (r_cnt == r_nbm1) begin
            w_state_nxt = S_WB;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_acc_nxt   = 64'd0;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State and datapath registers; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_osize       <= 2'd0;
      r_nbm1        <= 3'd0;
      r_cnt         <= 3'd0;
      r_acc         <= 64'd0;
      r_chunk_ready <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_busy        <= 1'b0;
      r_wb_data     <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_osize <= osize;
        r_nbm1  <= num_beats_m1;
      end
      r_chunk_ready <= (w_state_nxt == S_COLLECT);
      r_wb_valid    <= (w_state_nxt == S_WB);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_wb_data     <= (w_state_nxt == S_WB) ? w_acc_nxt : 64'd0;
    end
  end

  assign chunk_ready = r_chunk_ready;
  assign wb_valid    = r_wb_valid;
  assign wb_data     = r_wb_data;
  assign busy        = r_busy;

endmodule

// File: tb/tb_riscv_v_redand_collect.sv
// Self-checking bench: directed vector table, reset corner sequence and random
// reductions checked against a byte-level reference model.
module tb_riscv_v_redand_collect;

  localparam int NB = 16;
  localparam int BW = 8;
  localparam int DW = NB * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    osize;
  logic [2:0]    num_beats_m1;
  logic [63:0]   scalar_init;
  logic          chunk_valid;
  logic [DW-1:0] chunk_result;
  logic          chunk_ready;
  logic          wb_valid;
  logic [63:0]   wb_data;
  logic          wb_ready;
  logic          busy;

  int total = 0;
  int bad   = 0;

  riscv_v_redand_collect #(.NUM_BYTES(NB), .BYTE_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .osize(osize),
    .num_beats_m1(num_beats_m1), .scalar_init(scalar_init),
    .chunk_valid(chunk_valid), .chunk_result(chunk_result),
    .chunk_ready(chunk_ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_ready(wb_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       os;
    logic [2:0]       nbm1;
    logic [63:0]      scalar;
    logic [7:0][63:0] elems;
    int               gap;
    int               hold;
    logic [63:0]      exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Element width in bytes, from plain arithmetic.
  function automatic int ebytes(input logic [1:0] os);
    return 2 ** int'(os);
  endfunction

  // Place an element value into the top bytes of a beat; fill the rest.
  function automatic logic [DW-1:0] place(input logic [63:0] e, input logic [1:0] os,
                                          input logic [DW-1:0] fill);
    logic [DW-1:0] c;
    int            n;
    c = fill;
    n = ebytes(os);
    for (int b = 0; b < n; b++) c[(NB - n + b) * 8 +: 8] = e[b * 8 +: 8];
    return c;
  endfunction

  // Reference: gather the top n bytes, AND into a masked seed.
  function automatic logic [63:0] model(input logic [1:0] os, input logic [2:0] nbm1,
                                        input logic [63:0] scalar,
                                        input logic [7:0][DW-1:0] chunks);
    logic [63:0] acc;
    logic [63:0] e;
    int          n;
    n   = ebytes(os);
    acc = 64'd0;
    for (int b = 0; b < n; b++) acc[b * 8 +: 8] = scalar[b * 8 +: 8];
    for (int i = 0; i <= int'(nbm1); i++) begin
      e = 64'd0;
      for (int b = 0; b < n; b++) e[b * 8 +: 8] = chunks[i][(NB - n + b) * 8 +: 8];
      acc = acc & e;
    end
    return acc;
  endfunction

  // Drive one full reduction; entered and left on a falling edge.
  task automatic run(input logic [1:0] os, input logic [2:0] nbm1, input logic [63:0] scalar,
                     input logic [7:0][DW-1:0] chunks, input int gap, input int hold,
                     input logic [63:0] exp);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; osize = os; num_beats_m1 = nbm1; scalar_init = scalar;
    @(negedge clk);
    start = 1'b0; osize = 2'd0; num_beats_m1 = 3'd0; scalar_init = 64'd0;
    chk("start_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i <= int'(nbm1); i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          chunk_valid = 1'b0;
          chunk_result = {$urandom, $urandom, $urandom, $urandom};
          @(negedge clk);
        end
      end
      chunk_valid = 1'b1;
      chunk_result = chunks[i];
      chk("beat_ready", {63'd0, chunk_ready}, 64'd1);
      chk("beat_no_wb", {63'd0, wb_valid}, 64'd0);
      @(negedge clk);
    end
    chunk_valid = 1'b0;
    chk("wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("wb_data", wb_data, exp);
    chk("wb_ready_low", {63'd0, chunk_ready}, 64'd0);
    for (int k = 0; k < hold; k++) begin
      wb_ready = 1'b0;
      start = (k == 1);
      chunk_valid = (k == 2);
      chunk_result = {DW{1'b0}};
      @(negedge clk);
      chk("hold_valid", {63'd0, wb_valid}, 64'd1);
      chk("hold_data", wb_data, exp);
    end
    chunk_valid = 1'b0;
    wb_ready = 1'b1;
    start = (hold > 0);
    @(negedge clk);
    wb_ready = 1'b0;
    start = 1'b0;
    chk("rel_valid", {63'd0, wb_valid}, 64'd0);
    chk("rel_busy", {63'd0, busy}, 64'd0);
    chk("rel_ready", {63'd0, chunk_ready}, 64'd0);
  endtask

  vec_t                vt[6];
  logic [7:0][DW-1:0]  ch;
  logic [1:0]          ros;
  logic [2:0]          rnb;
  logic [63:0]         rsc;

  initial begin
    vt[0] = '{2'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, '{default: 64'd0}, 0, 0, 64'h0000_0000_F0F0_1234};
    vt[0].elems[0] = 64'hF0F0_1234;
    vt[1] = '{2'd0, 3'd3, 64'h0000_0000_0000_00FF, '{default: 64'd0}, 0, 0, 64'h66};
    vt[1].elems[0] = 64'hFE; vt[1].elems[1] = 64'h7F; vt[1].elems[2] = 64'hF7; vt[1].elems[3] = 64'hEF;
    vt[2] = '{2'd3, 3'd1, 64'h0F0F_0F0F_0F0F_0F0F, '{default: 64'd0}, 2, 0, 64'h0F0F_0000_0F0F_0F0F};
    vt[2].elems[0] = 64'hFFFF_0000_FFFF_FFFF; vt[2].elems[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vt[3] = '{2'd1, 3'd1, 64'h1234_5678_9ABC_FFFF, '{default: 64'd0}, 0, 5, 64'h3030};
    vt[3].elems[0] = 64'hF0F0; vt[3].elems[1] = 64'h3C3C;
    vt[4] = '{2'd1, 3'd7, 64'h0000_0000_0000_FFFF, '{default: 64'd0}, 0, 0, 64'hFF00};
    for (int i = 0; i < 8; i++) vt[4].elems[i] = 64'hFFFF & ~(64'd1 << i);
    vt[5] = '{2'd2, 3'd0, 64'hAAAA_AAAA_5555_FFFF, '{default: 64'd0}, 0, 2, 64'h5555_FFFF};
    vt[5].elems[0] = 64'hFFFF_FFFF;

    rst = 1'b1; start = 1'b0; osize = 2'd0; num_beats_m1 = 3'd0; scalar_init = 64'd0;
    chunk_valid = 1'b0; chunk_result = {DW{1'b0}}; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, chunk_ready}, 64'd0);
    chk("rst_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_data", wb_data, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    chunk_valid = 1'b1;
    chunk_result = {DW{1'b1}};
    @(negedge clk);
    chunk_valid = 1'b0;
    chk("idle_ignores_beat", {63'd0, chunk_ready | wb_valid | busy}, 64'd0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 8; i++) ch[i] = place(vt[v].elems[i], vt[v].os, {DW{1'b0}});
      run(vt[v].os, vt[v].nbm1, vt[v].scalar, ch, vt[v].gap, vt[v].hold, vt[v].exp);
    end

    // Reset after two of four 16b beats, then a clean one-beat reduction.
    start = 1'b1; osize = 2'd1; num_beats_m1 = 3'd3; scalar_init = 64'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chunk_valid = 1'b1; chunk_result = place(64'h00FF, 2'd1, {DW{1'b0}});
    @(negedge clk);
    chunk_result = place(64'h0F0F, 2'd1, {DW{1'b0}});
    @(negedge clk);
    rst = 1'b1; chunk_result = place(64'h0000, 2'd1, {DW{1'b0}});
    @(negedge clk);
    rst = 1'b0; chunk_valid = 1'b0;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_ready", {63'd0, chunk_ready}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      chunk_valid = 1'b1;
      @(negedge clk);
      chk("mrst_no_wb", {63'd0, wb_valid}, 64'd0);
    end
    chunk_valid = 1'b0;
    ch = '{default: {DW{1'b0}}};
    ch[0] = place(64'hABCD, 2'd1, {DW{1'b0}});
    run(2'd1, 3'd0, 64'hFFFF, ch, 0, 0, 64'hABCD);

    // Random reductions with random filler in the non-element bytes.
    for (int t = 0; t < 25; t++) begin
      ros = 2'($urandom_range(0, 3));
      rnb = 3'($urandom_range(0, 7));
      rsc = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) begin
        ch[i] = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 3) == 0) ch[i] = place(64'hFFFF_FFFF_FFFF_FFFF, ros, ch[i]);
      end
      run(ros, rnb, rsc, ch, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          model(ros, rnb, rsc, ch));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
